byte_lane_arbiter: RTL and testbench



---
 rtl/byte_lane_arbiter_pkg.sv | 18 +
 rtl/byte_lane_arbiter_if.sv | 27 ++
 rtl/byte_lane_arbiter_rr_pick.sv | 29 ++
 rtl/byte_lane_arbiter.sv | 173 +++++++++++++++++
 tb/tb_byte_lane_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/byte_lane_arbiter_pkg.sv
// Shared types and helpers for the byte-lane arbiter and its round-robin picker.
// Optional build macro for the arbiter: ARB_WORD_STATS_EN (per-lane word counters).
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        PAD  = 2'd2
    } arb_state_e;

    localparam int BYTES_PER_WORD_DEF = 4;

    // Index width for n items; never returns 0 so single-entry vectors stay legal.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/byte_lane_arbiter_if.sv
// Lane-side and packer-side signals of the byte-lane arbiter.
// master = arbiter view, slave = requesters/packer view.
interface byte_lane_arbiter_if import arb_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int LANE_W  = idx_w(NUM_REQ)
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_pop;
    logic                      down_ready;
    logic [DATA_W-1:0]         data_out;
    logic                      valid_out;
    logic [LANE_W-1:0]         lane_id;
    logic                      word_last;
    logic                      pad_err;

    modport master (
        input  req_valid, req_data, down_ready,
        output req_pop, data_out, valid_out, lane_id, word_last, pad_err
    );

    modport slave (
        output req_valid, req_data, down_ready,
        input  req_pop, data_out, valid_out, lane_id, word_last, pad_err
    );
endinterface

// File: rtl/byte_lane_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after last_grant, wrapping.
// Direction-agnostic, so the 32b->8b unpacker path can reuse it.
module rr_pick import arb_pkg::*; #(
    parameter int N = 4,
    parameter int W = idx_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic         any,
    output logic [W-1:0] idx
);
    logic         found;
    logic [W-1:0] cand;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        any   = |req;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = W'((int'(last_grant) + k) % N);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/byte_lane_arbiter.sv
// Round-robin arbiter feeding one 8b->32b packer; a grant lasts one whole word.
// Optional: define ARB_WORD_STATS_EN to add per-lane 16-bit completed-word counters.
module byte_lane_arbiter import arb_pkg::*; #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 8,
    parameter int BYTES_PER_WORD = BYTES_PER_WORD_DEF,
    parameter int STALL_MAX      = 15
) (
    input  logic                 clk_4f,
    input  logic                 reset_L,
    byte_lane_arbiter_if.master  bus
`ifdef ARB_WORD_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0] word_count
`endif
);
    localparam int LANE_W  = idx_w(NUM_REQ);
    localparam int CNT_W   = idx_w(BYTES_PER_WORD);
    localparam int STALL_W = $clog2(STALL_MAX + 1);

    localparam logic [CNT_W-1:0]   LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);
    localparam logic [STALL_W-1:0] STALL_TOP = STALL_W'(STALL_MAX);
    localparam logic [STALL_W-1:0] STALL_PRE = STALL_W'(STALL_MAX - 1);

    arb_state_e         state;
    logic [LANE_W-1:0]  grant;
    logic [LANE_W-1:0]  last_grant;
    logic [CNT_W-1:0]   byte_cnt;
    logic [STALL_W-1:0] stall_cnt;
    logic [DATA_W-1:0]  data_q;
    logic               valid_q;
    logic [LANE_W-1:0]  lane_id_q;
    logic               last_q;
    logic               pad_q;

    logic               pick_any;
    logic [LANE_W-1:0]  pick_idx;
    logic               gnt_valid;
    logic [DATA_W-1:0]  gnt_data;
    logic               pop;
    logic               word_done;

    rr_pick #(.N(NUM_REQ), .W(LANE_W)) u_pick (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .any        (pick_any),
        .idx        (pick_idx)
    );

    always_comb begin
        gnt_valid = 1'b0;
        gnt_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == LANE_W'(i)) begin
                gnt_valid = bus.req_valid[i];
                gnt_data  = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign pop = (state == XFER) && gnt_valid && bus.down_ready;

    always_comb begin
        bus.req_pop = '0;
        if (pop) bus.req_pop[grant] = 1'b1;
    end

    assign word_done = (byte_cnt == LAST_BYTE) &&
                       (pop || (state == PAD && bus.down_ready));

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= LANE_W'(NUM_REQ - 1);
            byte_cnt   <= '0;
            stall_cnt  <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            lane_id_q  <= '0;
            last_q     <= 1'b0;
            pad_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    if (pick_any) begin
                        grant     <= pick_idx;
                        lane_id_q <= pick_idx;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (pop) begin
                        // A pop always beats a stall expiring in the same cycle.
                        data_q    <= gnt_data;
                        valid_q   <= 1'b1;
                        stall_cnt <= '0;
                        if (word_done) begin
                            last_q     <= 1'b1;
                            byte_cnt   <= '0;
                            last_grant <= grant;
                            state      <= IDLE;
                        end else begin
                            last_q   <= 1'b0;
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end else begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        // Only a starved lane mid-word counts; backpressure never pads.
                        if (!gnt_valid && bus.down_ready && byte_cnt != '0) begin
                            if (stall_cnt == STALL_PRE) begin
                                stall_cnt <= STALL_TOP;
                                pad_q     <= 1'b1;
                                state     <= PAD;
                            end else if (stall_cnt != STALL_TOP) begin
                                stall_cnt <= stall_cnt + 1'b1;
                            end
                        end
                    end
                end
                PAD: begin
                    if (bus.down_ready) begin
                        data_q  <= '0;
                        valid_q <= 1'b1;
                        if (word_done) begin
                            last_q     <= 1'b1;
                            byte_cnt   <= '0;
                            stall_cnt  <= '0;
                            last_grant <= grant;
                            state      <= IDLE;
                        end else begin
                            last_q   <= 1'b0;
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end else begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.lane_id   = lane_id_q;
    assign bus.word_last = last_q;
    assign bus.pad_err   = pad_q;

`ifdef ARB_WORD_STATS_EN
    logic [15:0] wcnt [NUM_REQ];

    // NOTE: the counter array is reset element by element; it is flops, not a RAM, so this is legal and required.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < NUM_REQ; i++) wcnt[i] <= '0;
        end else if (word_done) begin
            wcnt[grant] <= wcnt[grant] + 16'd1;
        end
    end

    always_comb begin
        word_count = '0;
        for (int i = 0; i < NUM_REQ; i++) word_count[i*16 +: 16] = wcnt[i];
    end
`endif

endmodule

// File: tb/tb_byte_lane_arbiter.sv
// Scoreboard bench for byte_lane_arbiter: directed lane traffic, queued expectations, monitor compares.
// Covers the ARB_WORD_STATS_EN counters when that macro is defined.
module tb_byte_lane_arbiter;
    localparam int NREQ = 4;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  lane;
        logic        last;
        logic [7:0]  data;
    } exp_t;

    logic clk_4f;
    logic reset_L;

    byte_lane_arbiter_if #(.NUM_REQ(NREQ), .DATA_W(8)) bus ();

`ifdef ARB_WORD_STATS_EN
    logic [NREQ*16-1:0] word_count;
`endif

    byte_lane_arbiter #(
        .NUM_REQ(NREQ), .DATA_W(8), .BYTES_PER_WORD(4), .STALL_MAX(15)
    ) dut (
        .clk_4f  (clk_4f),
        .reset_L (reset_L),
        .bus     (bus)
`ifdef ARB_WORD_STATS_EN
        ,
        .word_count (word_count)
`endif
    );

    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          base;
    logic [31:0] word_acc = '0;
    logic [31:0] last_word = '0;
    exp_t        exp_q[$];
    logic [7:0]  lane_q[NREQ][$];

    initial begin
        clk_4f = 1'b0;
        forever #5 clk_4f = ~clk_4f;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic expect_byte(input int lane, input logic [7:0] d, input logic last, input int c);
        exp_t e;
        e.cyc  = 32'(c);
        e.lane = 8'(lane);
        e.last = last;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk_4f);
        #3;
    endtask

    task automatic wait_cyc(input int target);
        int g = 0;
        while (cyc < target && g < 500) begin
            step();
            g++;
        end
    endtask

    task automatic wait_drain(input string name);
        int g = 0;
        while (exp_q.size() > 0 && g < 300) begin
            step();
            g++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk_4f);
        reset_L = 1'b0;
        bus.down_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) lane_q[i].delete();
        exp_q.delete();
        repeat (2) @(negedge clk_4f);
        reset_L = 1'b1;
    endtask

    // Lane model: each lane is a byte FIFO; a sampled pop consumes the front byte.
    initial begin
        logic [NREQ-1:0]   rv;
        logic [NREQ*8-1:0] rd;
        logic [NREQ-1:0]   cap;
        forever begin
            @(negedge clk_4f);
            #1;
            rv = '0;
            rd = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (lane_q[i].size() > 0) begin
                    rv[i]        = 1'b1;
                    rd[i*8 +: 8] = lane_q[i][0];
                end
            end
            bus.req_valid = rv;
            bus.req_data  = rd;
            #1;
            cap = bus.req_pop;
            @(posedge clk_4f);
            for (int i = 0; i < NREQ; i++)
                if (cap[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
        end
    end

    // Monitor: every valid byte is matched against the head of the expectation queue.
    initial begin
        exp_t act;
        exp_t e;
        forever begin
            @(posedge clk_4f);
            #2;
            cyc++;
            if (bus.valid_out) begin
                act.cyc  = 32'(cyc);
                act.lane = 8'(bus.lane_id);
                act.last = bus.word_last;
                act.data = bus.data_out;
                word_acc = {word_acc[23:0], bus.data_out};
                if (bus.word_last) last_word = word_acc;
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_unexpected: got lane %0d data 0x%0h at cycle %0d, want no output",
                             bus.lane_id, bus.data_out, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_byte{cyc,lane,last,data}", 64'(act), 64'(e));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.down_ready = 1'b1;
        reset_L        = 1'b1;
        #1 reset_L = 1'b0;
        #2;
        check("rst_valid_out", 64'(bus.valid_out), 64'd0);
        check("rst_data_out",  64'(bus.data_out),  64'd0);
        check("rst_lane_id",   64'(bus.lane_id),   64'd0);
        check("rst_word_last", 64'(bus.word_last), 64'd0);
        check("rst_pad_err",   64'(bus.pad_err),   64'd0);

        // Single lane word: data two cycles after request, four consecutive bytes.
        apply_reset();
        base = cyc;
        for (int b = 0; b < 4; b++) begin
            lane_q[0].push_back(8'hA1 + 8'(b));
            expect_byte(0, 8'hA1 + 8'(b), b == 3, base + 2 + b);
        end
        wait_drain("t1_drain");
        check("t1_packed_word", 64'(last_word), 64'hA1A2A3A4);

        // All lanes busy: grant order 0,1,2,3,0 with one bubble between words.
        apply_reset();
        base = cyc;
        for (int i = 0; i < NREQ; i++)
            for (int b = 0; b < ((i == 0) ? 8 : 4); b++)
                lane_q[i].push_back(8'h40 + 8'(16 * i) + 8'(b));
        for (int w = 0; w < 5; w++) begin
            int ln;
            ln = w % 4;
            for (int b = 0; b < 4; b++)
                expect_byte(ln, 8'h40 + 8'(16 * ln) + 8'((w == 4) ? b + 4 : b), b == 3,
                            base + 2 + 5 * w + b);
        end
        wait_drain("t2_drain");

        // Lane 2 starves after two bytes: zero padding completes the word.
        apply_reset();
        base = cyc;
        lane_q[2].push_back(8'h55);
        lane_q[2].push_back(8'h66);
        expect_byte(2, 8'h55, 1'b0, base + 2);
        expect_byte(2, 8'h66, 1'b0, base + 3);
        expect_byte(2, 8'h00, 1'b0, base + 19);
        expect_byte(2, 8'h00, 1'b1, base + 20);
        wait_cyc(base + 17);
        check("t3_pad_err_before_timeout", 64'(bus.pad_err), 64'd0);
        wait_cyc(base + 18);
        check("t3_pad_err_at_timeout", 64'(bus.pad_err), 64'd1);
        wait_drain("t3_drain");
        @(negedge clk_4f);
        base = cyc;
        for (int b = 0; b < 4; b++) begin
            lane_q[0].push_back(8'hC1 + 8'(b));
            expect_byte(0, 8'hC1 + 8'(b), b == 3, base + 2 + b);
        end
        wait_drain("t3_next_drain");
        check("t3_pad_err_sticky", 64'(bus.pad_err), 64'd1);

        // Backpressure for 20 cycles mid-word: no pops, no padding.
        apply_reset();
        base = cyc;
        for (int b = 0; b < 4; b++) lane_q[1].push_back(8'h11 + 8'(b));
        expect_byte(1, 8'h11, 1'b0, base + 2);
        expect_byte(1, 8'h12, 1'b0, base + 3);
        expect_byte(1, 8'h13, 1'b0, base + 24);
        expect_byte(1, 8'h14, 1'b1, base + 25);
        wait_cyc(base + 3);
        @(negedge clk_4f);
        bus.down_ready = 1'b0;
        #2;
        check("t4_no_pop_under_backpressure", 64'(bus.req_pop), 64'd0);
        repeat (20) @(negedge clk_4f);
        check("t4_pad_err_under_backpressure", 64'(bus.pad_err), 64'd0);
        bus.down_ready = 1'b1;
        wait_drain("t4_drain");
        check("t4_pad_err_after", 64'(bus.pad_err), 64'd0);

        // Reset mid-word, then lanes 0 and 1 compete: lane 0 wins first.
        apply_reset();
        base = cyc;
        for (int b = 0; b < 4; b++) lane_q[1].push_back(8'h21 + 8'(b));
        for (int b = 0; b < 3; b++) expect_byte(1, 8'h21 + 8'(b), 1'b0, base + 2 + b);
        wait_cyc(base + 4);
        reset_L = 1'b0;
        #1;
        check("t5_async_valid_out", 64'(bus.valid_out), 64'd0);
        check("t5_async_data_out",  64'(bus.data_out),  64'd0);
        check("t5_async_lane_id",   64'(bus.lane_id),   64'd0);
        check("t5_async_word_last", 64'(bus.word_last), 64'd0);
        check("t5_async_pad_err",   64'(bus.pad_err),   64'd0);
        check("t5_partial_bytes_seen", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < NREQ; i++) lane_q[i].delete();
        repeat (2) @(negedge clk_4f);
        base = cyc;
        for (int b = 0; b < 4; b++) begin
            lane_q[0].push_back(8'h31 + 8'(b));
            lane_q[1].push_back(8'h41 + 8'(b));
        end
        for (int b = 0; b < 4; b++) expect_byte(0, 8'h31 + 8'(b), b == 3, base + 2 + b);
        for (int b = 0; b < 4; b++) expect_byte(1, 8'h41 + 8'(b), b == 3, base + 7 + b);
        reset_L = 1'b1;
        wait_drain("t5_drain");

`ifdef ARB_WORD_STATS_EN
        // Three lane-0 words around one padded lane-3 word.
        apply_reset();
        base = cyc;
        for (int b = 0; b < 12; b++) lane_q[0].push_back(8'h80 + 8'(b));
        lane_q[3].push_back(8'hD1);
        lane_q[3].push_back(8'hD2);
        for (int b = 0; b < 4; b++) expect_byte(0, 8'h80 + 8'(b), b == 3, base + 2 + b);
        expect_byte(3, 8'hD1, 1'b0, base + 7);
        expect_byte(3, 8'hD2, 1'b0, base + 8);
        expect_byte(3, 8'h00, 1'b0, base + 24);
        expect_byte(3, 8'h00, 1'b1, base + 25);
        for (int b = 0; b < 4; b++) expect_byte(0, 8'h84 + 8'(b), b == 3, base + 27 + b);
        for (int b = 0; b < 4; b++) expect_byte(0, 8'h88 + 8'(b), b == 3, base + 32 + b);
        wait_drain("stats_drain");
        check("stats_lane0", 64'(word_count[15:0]),  64'd3);
        check("stats_lane1", 64'(word_count[31:16]), 64'd0);
        check("stats_lane2", 64'(word_count[47:32]), 64'd0);
        check("stats_lane3", 64'(word_count[63:48]), 64'd1);
`endif

        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
